// File: rtl/spdif_transmitter.sv
// -----------------------------------------------------------------------------
// spdif_transmitter
//
// Consumer IEC 60958 (S/PDIF) biphase-mark encoder for a 16-bit stereo stream.
// One left/right pair is taken from a holding register at the start of every
// frame (cell 0 of the left subframe). Each subframe is 32 slots of two cells:
// preamble, 8 zero slots, 16 audio bits LSB first, then V, U, C and P.
// Frames are grouped into blocks of `Frames`; frame 0 of a block uses the B
// preamble.
//
// Optional feature: define SPDIF_TX_CHANNEL_STATUS_EN to emit a consumer
// channel-status block on C (bit 2 copy permitted, bit 25 = 48 kHz). Without
// the macro, C is 0 in every subframe.
//
// Ports:
//   Clk          system clock
//   Reset        asynchronous, active-high reset
//   Cell_Ena     one-Clk strobe per biphase cell (never in consecutive cycles)
//   Active       stream valid; sampled at each transfer, low forces V=1, audio 0
//   Load         one-Clk strobe, latches Audio_L/Audio_R into the holding reg
//   Audio_L/R    16-bit two's complement samples
//   S_PDIF_Out   registered biphase-mark output
//   Sample_Taken pulse: holding register moved to the working pair
//   Underrun     pulse: frame started with the holding register empty
//   Overrun      pulse: Load arrived while the holding register was full
//
// Handshake: Load is a fire-and-forget strobe with no ready; the Full flag
// only reports (via Overrun/Underrun) whether the producer kept pace.
// -----------------------------------------------------------------------------
module spdif_transmitter #(
  parameter int Frames = 192
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Cell_Ena,
  input  logic        Active,
  input  logic        Load,
  input  logic [15:0] Audio_L,
  input  logic [15:0] Audio_R,
  output logic        S_PDIF_Out,
  output logic        Sample_Taken,
  output logic        Underrun,
  output logic        Overrun
);

  localparam int FW = (Frames > 1) ? $clog2(Frames) : 1;

  logic [5:0]    cell_q,   cell_d;
  logic          sub_q,    sub_d;
  logic [FW-1:0] frame_q,  frame_d;
  logic          out_q,    out_d;
  logic          pinv_q,   pinv_d;
  logic [15:0]   hold_l_q, hold_l_d;
  logic [15:0]   hold_r_q, hold_r_d;
  logic          full_q,   full_d;
  logic [15:0]   work_l_q, work_l_d;
  logic [15:0]   work_r_q, work_r_d;
  logic          v_q,      v_d;
  logic          taken_q,  taken_d;
  logic          under_q,  under_d;
  logic          over_q,   over_d;

  logic [4:0]  slot;
  logic [4:0]  aidx;
  logic        transfer;
  logic [15:0] tx_sample;
  logic        c_bit;
  logic        parity;
  logic        data_bit;
  logic [7:0]  pre_pat;
  logic        pre_inv;
  logic        cell_val;

  assign slot     = cell_q[5:1];
  assign aidx     = slot - 5'd12;
  assign transfer = Cell_Ena && (cell_q == 6'd0) && !sub_q;

  assign tx_sample = v_q ? 16'h0000 : (sub_q ? work_r_q : work_l_q);

`ifdef SPDIF_TX_CHANNEL_STATUS_EN
  assign c_bit = (frame_q == FW'(2)) || (frame_q == FW'(25));
`else
  assign c_bit = 1'b0;
`endif

  // Even parity over slots 4-30: the zero slots and U contribute nothing.
  assign parity = (^tx_sample) ^ v_q ^ c_bit;

  always_comb begin
    data_bit = 1'b0;
    if (slot >= 5'd12 && slot <= 5'd27) begin
      data_bit = tx_sample[aidx[3:0]];
    end else begin
      case (slot)
        5'd28:   data_bit = v_q;
        5'd30:   data_bit = c_bit;
        5'd31:   data_bit = parity;
        default: data_bit = 1'b0;
      endcase
    end
  end

  assign pre_pat = sub_q ? 8'b11100100 :
                   ((frame_q == '0) ? 8'b11101000 : 8'b11100010);

  // The preamble polarity is set by the level just before its first cell and
  // must stay fixed for all 8 cells, so it is captured at cell 0.
  assign pre_inv = (cell_q == 6'd0) ? out_q : pinv_q;

  always_comb begin
    if (cell_q < 6'd8) begin
      cell_val = pre_pat[3'd7 - cell_q[2:0]] ^ pre_inv;
    end else if (!cell_q[0]) begin
      cell_val = ~out_q;
    end else begin
      cell_val = out_q ^ data_bit;
    end
  end

  always_comb begin
    cell_d   = cell_q;
    sub_d    = sub_q;
    frame_d  = frame_q;
    out_d    = out_q;
    pinv_d   = pinv_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    full_d   = full_q;
    work_l_d = work_l_q;
    work_r_d = work_r_q;
    v_d      = v_q;
    taken_d  = 1'b0;
    under_d  = 1'b0;
    over_d   = 1'b0;

    if (Cell_Ena) begin
      out_d  = cell_val;
      pinv_d = pre_inv;
      cell_d = cell_q + 6'd1;
      if (cell_q == 6'd63) begin
        sub_d = ~sub_q;
        if (sub_q) begin
          frame_d = (frame_q == FW'(Frames - 1)) ? '0 : frame_q + FW'(1);
        end
      end
    end

    if (transfer) begin
      v_d = ~Active;
      if (full_q) begin
        work_l_d = hold_l_q;
        work_r_d = hold_r_q;
        full_d   = 1'b0;
        taken_d  = 1'b1;
      end else begin
        under_d  = 1'b1;
      end
    end

    // A Load coinciding with a transfer refills the register just emptied,
    // so it is not an overrun.
    if (Load) begin
      hold_l_d = Audio_L;
      hold_r_d = Audio_R;
      full_d   = 1'b1;
      over_d   = full_q && !transfer;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cell_q   <= '0;
      sub_q    <= 1'b0;
      frame_q  <= '0;
      out_q    <= 1'b0;
      pinv_q   <= 1'b0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      full_q   <= 1'b0;
      work_l_q <= '0;
      work_r_q <= '0;
      v_q      <= 1'b0;
      taken_q  <= 1'b0;
      under_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      cell_q   <= cell_d;
      sub_q    <= sub_d;
      frame_q  <= frame_d;
      out_q    <= out_d;
      pinv_q   <= pinv_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      full_q   <= full_d;
      work_l_q <= work_l_d;
      work_r_q <= work_r_d;
      v_q      <= v_d;
      taken_q  <= taken_d;
      under_q  <= under_d;
      over_q   <= over_d;
    end
  end

  assign S_PDIF_Out   = out_q;
  assign Sample_Taken = taken_q;
  assign Underrun     = under_q;
  assign Overrun      = over_q;

endmodule

// File: tb/tb_spdif_transmitter.sv
// -----------------------------------------------------------------------------
// tb_spdif_transmitter
//
// Stimulus tasks drive one Clk cycle at a time and update a frame-level model
// of the link (global cell index, holding/working pairs, previous line level).
// At the start of each subframe the model builds the whole 32-slot word and
// its 64 biphase cells and queues them; status pulses are queued per cycle.
// A monitor pops and compares after every rising edge.
// -----------------------------------------------------------------------------
module tb_spdif_transmitter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Cell_Ena;
  logic        Active;
  logic        Load;
  logic [15:0] Audio_L;
  logic [15:0] Audio_R;
  logic        S_PDIF_Out;
  logic        Sample_Taken;
  logic        Underrun;
  logic        Overrun;

  spdif_transmitter #(.Frames(192)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Cell_Ena     (Cell_Ena),
    .Active       (Active),
    .Load         (Load),
    .Audio_L      (Audio_L),
    .Audio_R      (Audio_R),
    .S_PDIF_Out   (S_PDIF_Out),
    .Sample_Taken (Sample_Taken),
    .Underrun     (Underrun),
    .Overrun      (Overrun)
  );

  // ---------------- clock ----------------
  always #10 Clk = ~Clk;

  // ---------------- scoreboard state ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  logic       exp_q[$];
  logic [2:0] pulse_q[$];

  // reference model
  longint      m_idx;
  logic [15:0] m_hl, m_hr, m_wl, m_wr;
  logic        m_full, m_v, m_last;

  // monitor state
  logic       mon_ena;
  logic       mon_level;
  logic       mon_exp;
  logic [2:0] mon_p;
  int         cnt_taken, cnt_under, cnt_over;
  logic [7:0] first8;
  int         obs_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic cs_bit(input int frame);
`ifdef SPDIF_TX_CHANNEL_STATUS_EN
    return (frame == 2) || (frame == 25);
`else
    return 1'b0;
`endif
  endfunction

  // Builds one subframe from the slot rules and queues its 64 cells.
  task automatic push_subframe();
    logic        right;
    int          frame;
    logic [15:0] a;
    logic [31:0] bits;
    logic [7:0]  pat;
    logic        inv, lvl, p;
    right = ((m_idx / 64) % 2) == 1;
    frame = int'((m_idx / 128) % 192);
    a     = m_v ? 16'h0000 : (right ? m_wr : m_wl);
    bits  = '0;
    for (int i = 0; i < 16; i++) bits[12 + i] = a[i];
    bits[28] = m_v;
    bits[30] = cs_bit(frame);
    p = 1'b0;
    for (int i = 4; i <= 30; i++) p = p ^ bits[i];
    bits[31] = p;
    pat = right ? 8'b11100100 : ((frame == 0) ? 8'b11101000 : 8'b11100010);
    inv = m_last;
    lvl = m_last;
    for (int i = 7; i >= 0; i--) begin
      lvl = pat[i] ^ inv;
      exp_q.push_back(lvl);
    end
    for (int s = 4; s < 32; s++) begin
      lvl = ~lvl;
      exp_q.push_back(lvl);
      if (bits[s]) lvl = ~lvl;
      exp_q.push_back(lvl);
    end
    m_last = lvl;
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic ena, input logic ld, input logic [15:0] l, input logic [15:0] r);
    logic st, un, ov;
    st = 1'b0; un = 1'b0; ov = 1'b0;
    if (ena && (m_idx % 128) == 0) begin
      m_v = ~Active;
      if (m_full) begin
        m_wl = m_hl; m_wr = m_hr; m_full = 1'b0; st = 1'b1;
      end else begin
        un = 1'b1;
      end
    end
    if (ld) begin
      if (m_full) ov = 1'b1;
      m_hl = l; m_hr = r; m_full = 1'b1;
    end
    if (ena && (m_idx % 64) == 0) push_subframe();
    if (ena) m_idx++;
    pulse_q.push_back({st, un, ov});
    Cell_Ena = ena;
    Load     = ld;
    Audio_L  = l;
    Audio_R  = r;
    @(negedge Clk);
  endtask

  function automatic logic rnd_load(input int per_mille);
    return $urandom_range(999, 0) < per_mille;
  endfunction

  task automatic run_cells(input int n, input int gmin, input int gmax, input int load_pm);
    for (int i = 0; i < n; i++) begin
      int g;
      g = $urandom_range(gmax, gmin);
      tick(1'b1, rnd_load(load_pm), 16'($urandom), 16'($urandom));
      for (int k = 1; k < g; k++) tick(1'b0, rnd_load(load_pm), 16'($urandom), 16'($urandom));
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; Cell_Ena = 1'b0; Load = 1'b0;
    exp_q.delete(); pulse_q.delete();
    m_idx = 0; m_full = 1'b0; m_v = 1'b0; m_last = 1'b0;
    m_hl = '0; m_hr = '0; m_wl = '0; m_wr = '0;
    mon_level = 1'b0; obs_n = 0;
    @(negedge Clk);
    @(negedge Clk);
    check("rst_out",   S_PDIF_Out,   0);
    check("rst_taken", Sample_Taken, 0);
    check("rst_under", Underrun,     0);
    check("rst_over",  Overrun,      0);
    Reset = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(posedge Clk) begin
    mon_ena = Cell_Ena;
    #1;
    if (Sample_Taken) cnt_taken++;
    if (Underrun)     cnt_under++;
    if (Overrun)      cnt_over++;
    if (pulse_q.size() > 0) begin
      mon_p = pulse_q.pop_front();
      check("pulses", {29'b0, Sample_Taken, Underrun, Overrun}, {29'b0, mon_p});
    end
    if (!Reset) begin
      if (mon_ena) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL cell_queue: got cell %0b with no expectation queued", S_PDIF_Out);
        end else begin
          mon_exp = exp_q.pop_front();
          check("cell", S_PDIF_Out, mon_exp);
          mon_level = mon_exp;
          if (obs_n < 8) first8[7 - obs_n] = S_PDIF_Out;
          obs_n++;
        end
      end else begin
        check("hold_level", S_PDIF_Out, mon_level);
      end
    end
  end

  // ---------------- tests ----------------
  initial begin
    Reset = 1'b1; Cell_Ena = 1'b0; Load = 1'b0; Active = 1'b1;
    Audio_L = '0; Audio_R = '0;
    cnt_taken = 0; cnt_under = 0; cnt_over = 0;

    // Reset output: first B preamble and the 8001/7FFE pair.
    do_reset();
    cnt_taken = 0; cnt_under = 0; cnt_over = 0;
    tick(1'b0, 1'b1, 16'h8001, 16'h7FFE);
    run_cells(128, 8, 8, 0);
    check("first8_B", {24'b0, first8}, 32'h000000E8);
    check("first_taken", cnt_taken, 1);
    check("first_under", cnt_under, 0);

    // No Load: one underrun per frame, preambles M/W continue.
    cnt_under = 0;
    run_cells(256, 2, 4, 0);
    check("noload_under", cnt_under, 2);

    // Double Load within a frame: one overrun, second pair sent.
    cnt_taken = 0; cnt_over = 0;
    tick(1'b0, 1'b1, 16'h1234, 16'h5678);
    tick(1'b0, 1'b1, 16'hA5C3, 16'h0F0F);
    run_cells(128, 2, 3, 0);
    check("dbl_over",  cnt_over,  1);
    check("dbl_taken", cnt_taken, 1);

    // Load at the transfer edge: old pair first, new pair next frame.
    cnt_taken = 0; cnt_over = 0;
    tick(1'b0, 1'b1, 16'h00FF, 16'hFF00);
    tick(1'b1, 1'b1, 16'h7FFF, 16'h8000);
    tick(1'b0, 1'b0, 16'h0000, 16'h0000);
    run_cells(255, 2, 3, 0);
    check("lat_over",  cnt_over,  0);
    check("lat_taken", cnt_taken, 2);

    // Inactive stream: V=1, audio forced to 0.
    Active = 1'b0;
    tick(1'b0, 1'b1, 16'hFFFF, 16'h1111);
    run_cells(128, 2, 3, 0);
    Active = 1'b1;

    // Reset in mid-stream, then a full block plus wrap with random traffic.
    run_cells(50, 2, 3, 200);
    do_reset();
    for (int chunk = 0; chunk < 12; chunk++) begin
      Active = ($urandom_range(3, 0) != 0);
      run_cells(16 * 128, 2, 2, 4);
    end
    Active = 1'b1;
    run_cells(128 + 64, 2, 2, 4);
    check("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
